// File: rtl/sram_mem_ctrl.sv
// rtl/sram_mem_ctrl.sv - MEM-stage responder serving 32-bit loads/stores as two 16-bit async SRAM accesses
module sram_mem_ctrl #(
    parameter int unsigned DATA_BASE = 1024,
    parameter int unsigned HALF_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        pause,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    localparam logic [3:0]  LAST_CNT = 4'(HALF_WAIT - 1);
    localparam logic [31:0] BASE     = 32'(DATA_BASE);

    state_t      state;
    logic [3:0]  cnt;
    logic        op_wr;
    logic [16:0] idx_q;
    logic [31:0] data_q;

    logic [31:0] off;
    logic        req;
    logic        last;
    logic        active;
    logic        half;
    logic        unused_off;

    assign off        = address - BASE;
    assign unused_off = ^{off[31:19], off[1:0]};
    assign req        = wr_en | rd_en;
    assign last       = (cnt == LAST_CNT);

    // DONE always returns to IDLE so a request still held by the frozen pipeline is not served twice.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            op_wr     <= 1'b0;
            idx_q     <= 17'd0;
            data_q    <= 32'd0;
            read_data <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        op_wr  <= wr_en;
                        idx_q  <= off[18:2];
                        data_q <= write_data;
                        cnt    <= 4'd0;
                        state  <= LO;
                    end
                end
                LO: begin
                    if (last) begin
                        if (!op_wr) read_data[15:0] <= SRAM_DQ;
                        cnt   <= 4'd0;
                        state <= HI;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                HI: begin
                    if (last) begin
                        if (!op_wr) read_data[31:16] <= SRAM_DQ;
                        cnt   <= 4'd0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pins decode from state only; reset gates them so an aborted access releases the bus at once.
    assign active    = rst && ((state == LO) || (state == HI));
    assign half      = (state == HI);
    assign SRAM_ADDR = active ? {idx_q, half} : 18'd0;
    assign SRAM_WE_N = !(active && op_wr);
    assign SRAM_OE_N = !(active && !op_wr);
    assign SRAM_DQ   = (active && op_wr) ? (half ? data_q[31:16] : data_q[15:0]) : 16'bz;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    assign pause = req && (state != DONE) && rst;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// tb/tb_sram_mem_ctrl.sv - directed self-checking bench for sram_mem_ctrl
module tb_sram_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, write_data, read_data;
    logic        pause;
    wire  [15:0] dq0;
    logic [17:0] addr0;
    logic        we_n0, oe_n0, ce_n0, ub_n0, lb_n0;

    logic        wr1, rd1;
    logic [31:0] addr1, wd1, read_data1;
    logic        pause1;
    wire  [15:0] dq1;
    logic [17:0] sram_addr1;
    logic        we_n1, oe_n1, ce_n1, ub_n1, lb_n1;

    logic [15:0] mem0 [0:262143];
    logic [15:0] mem1 [0:262143];

    int total  = 0;
    int passed = 0;
    int cyc, we_low, oe_low;

    always #5 clk = ~clk;

    sram_mem_ctrl u0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
        .write_data(write_data), .read_data(read_data), .pause(pause),
        .SRAM_DQ(dq0), .SRAM_ADDR(addr0), .SRAM_WE_N(we_n0), .SRAM_OE_N(oe_n0),
        .SRAM_CE_N(ce_n0), .SRAM_UB_N(ub_n0), .SRAM_LB_N(lb_n0)
    );

    sram_mem_ctrl #(.DATA_BASE(1024), .HALF_WAIT(1)) u1 (
        .clk(clk), .rst(rst), .wr_en(wr1), .rd_en(rd1), .address(addr1),
        .write_data(wd1), .read_data(read_data1), .pause(pause1),
        .SRAM_DQ(dq1), .SRAM_ADDR(sram_addr1), .SRAM_WE_N(we_n1), .SRAM_OE_N(oe_n1),
        .SRAM_CE_N(ce_n1), .SRAM_UB_N(ub_n1), .SRAM_LB_N(lb_n1)
    );

    // Asynchronous SRAM models: read drives the bus, write commits while WE_N is low at a clock edge.
    assign dq0 = (!oe_n0 && we_n0) ? mem0[addr0] : 16'bz;
    assign dq1 = (!oe_n1 && we_n1) ? mem1[sram_addr1] : 16'bz;

    always @(posedge clk) if (!we_n0) mem0[addr0] <= dq0;
    always @(posedge clk) if (!we_n1) mem1[sram_addr1] <= dq1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_access(output int c, output int w, output int o);
        c = 0; w = 0; o = 0;
        while (pause && c < 20) begin
            if (!we_n0) w++;
            if (!oe_n0) o++;
            step();
            c++;
        end
    endtask

    initial begin
        for (int i = 0; i < 262144; i++) begin
            mem0[i] = 16'h0;
            mem1[i] = 16'h0;
        end
        mem0[5] = 16'h2222;
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b1; address = 32'd1024; write_data = 32'd0;
        wr1 = 1'b0; rd1 = 1'b0; addr1 = 32'd0; wd1 = 32'd0;

        step(); step(); step();
        check("rst_pause", {31'd0, pause}, 32'd0);
        check("rst_we_n", {31'd0, we_n0}, 32'd1);
        check("rst_oe_n", {31'd0, oe_n0}, 32'd1);
        check("rst_read_data", read_data, 32'd0);
        check("tied_pins", {26'd0, ce_n0, ub_n0, lb_n0, ce_n1, ub_n1, lb_n1}, 32'd0);

        rst = 1'b1; rd_en = 1'b0;
        step();
        check("idle_pause", {31'd0, pause}, 32'd0);

        wr_en = 1'b1; address = 32'd1024; write_data = 32'hDEADBEEF;
        #1;
        check("store_pause_idle", {31'd0, pause}, 32'd1);
        run_access(cyc, we_low, oe_low);
        check("store_pause_cycles", cyc, 32'd5);
        check("store_we_low", we_low, 32'd4);
        check("store_oe_low", oe_low, 32'd0);
        check("store_done_we_n", {31'd0, we_n0}, 32'd1);
        check("store_mem0", {16'd0, mem0[0]}, 32'h0000BEEF);
        check("store_mem1", {16'd0, mem0[1]}, 32'h0000DEAD);
        check("store_keeps_rd", read_data, 32'd0);

        wr_en = 1'b0; rd_en = 1'b1;
        #1;
        check("done_pause_low", {31'd0, pause}, 32'd0);
        step();
        check("load_idle_pause", {31'd0, pause}, 32'd1);
        check("load_idle_oe_n", {31'd0, oe_n0}, 32'd1);
        run_access(cyc, we_low, oe_low);
        check("load_pause_cycles", cyc, 32'd5);
        check("load_oe_low", oe_low, 32'd4);
        check("load_data", read_data, 32'hDEADBEEF);
        rd_en = 1'b0;
        step();

        wr_en = 1'b1; address = 32'd1028; write_data = 32'h00000001;
        #1;
        run_access(cyc, we_low, oe_low);
        check("b2b_store_cycles", cyc, 32'd5);
        wr_en = 1'b0; rd_en = 1'b1;
        #1;
        check("b2b_done_gap", {31'd0, pause}, 32'd0);
        step();
        check("b2b_idle_pause", {31'd0, pause}, 32'd1);
        check("b2b_idle_oe_n", {31'd0, oe_n0}, 32'd1);
        run_access(cyc, we_low, oe_low);
        check("b2b_load_cycles", cyc, 32'd5);
        check("b2b_load_data", read_data, 32'h00000001);
        check("b2b_mem2", {16'd0, mem0[2]}, 32'h00000001);
        check("b2b_mem3", {16'd0, mem0[3]}, 32'h00000000);
        rd_en = 1'b0;
        step();

        wr_en = 1'b1; address = 32'd1032; write_data = 32'hCAFEF00D;
        #1;
        step(); step(); step();
        check("mid_hi_addr", {14'd0, addr0}, 32'd5);
        check("mid_hi_we_n", {31'd0, we_n0}, 32'd0);
        rst = 1'b0;
        #1;
        check("mid_rst_pause", {31'd0, pause}, 32'd0);
        check("mid_rst_we_n", {31'd0, we_n0}, 32'd1);
        step();
        rst = 1'b1; wr_en = 1'b0;
        #1;
        check("mid_after_we_n", {31'd0, we_n0}, 32'd1);
        check("mid_after_rd", read_data, 32'd0);
        step();
        check("mid_idle_we_n", {31'd0, we_n0}, 32'd1);
        check("mid_idle_addr", {14'd0, addr0}, 32'd0);
        check("mid_mem4", {16'd0, mem0[4]}, 32'h0000F00D);
        check("mid_mem5", {16'd0, mem0[5]}, 32'h00002222);
        rd_en = 1'b1;
        #1;
        run_access(cyc, we_low, oe_low);
        check("mid_load_cycles", cyc, 32'd5);
        check("mid_load_data", read_data, 32'h2222F00D);
        rd_en = 1'b0;
        step();

        wr1 = 1'b1; rd1 = 1'b1; addr1 = 32'd1020; wd1 = 32'h12345678;
        #1;
        check("hw1_pause_idle", {31'd0, pause1}, 32'd1);
        check("hw1_idle_addr", {14'd0, sram_addr1}, 32'd0);
        step();
        check("hw1_lo_addr", {14'd0, sram_addr1}, 32'h0003FFFE);
        check("hw1_lo_we_n", {31'd0, we_n1}, 32'd0);
        check("hw1_lo_oe_n", {31'd0, oe_n1}, 32'd1);
        check("hw1_lo_dq", {16'd0, dq1}, 32'h00005678);
        check("hw1_lo_pause", {31'd0, pause1}, 32'd1);
        step();
        check("hw1_hi_addr", {14'd0, sram_addr1}, 32'h0003FFFF);
        check("hw1_hi_dq", {16'd0, dq1}, 32'h00001234);
        check("hw1_hi_pause", {31'd0, pause1}, 32'd1);
        step();
        check("hw1_done_pause", {31'd0, pause1}, 32'd0);
        check("hw1_done_we_n", {31'd0, we_n1}, 32'd1);
        check("hw1_mem_lo", {16'd0, mem1[18'h3FFFE]}, 32'h00005678);
        check("hw1_mem_hi", {16'd0, mem1[18'h3FFFF]}, 32'h00001234);
        check("hw1_rd_kept", read_data1, 32'd0);
        wr1 = 1'b0; rd1 = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
